// File: rtl/altivec_issue_arbiter.sv
// Round-robin issue arbiter sharing one vector execution unit among NUM_REQ requesters.
// Issued requester IDs are queued in order so each result is routed back to its owner.
module altivec_issue_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int OUT_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*128-1:0]        req_vra,
    input  logic [NUM_REQ*128-1:0]        req_vrb,
    input  logic [NUM_REQ*8-1:0]          req_ins,
    input  logic [NUM_REQ-1:0]            req_rc,
    output logic [127:0]                  vra,
    output logic [127:0]                  vrb,
    output logic [7:0]                    ins,
    output logic                          rc,
    output logic                          vra_en,
    output logic                          vrb_en,
    output logic                          ins_en,
    input  logic                          dut_busy,
    input  logic                          vrt_en,
    input  logic [127:0]                  vrt,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [127:0]                  rsp_vrt,
    output logic [$clog2(OUT_DEPTH):0]    outstanding,
    output logic                          err_orphan
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CW  = $clog2(OUT_DEPTH) + 1;

    logic [127:0] vra_arr [NUM_REQ];
    logic [127:0] vrb_arr [NUM_REQ];
    logic [7:0]   ins_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign vra_arr[gi] = req_vra[gi*128 +: 128];
            assign vrb_arr[gi] = req_vrb[gi*128 +: 128];
            assign ins_arr[gi] = req_ins[gi*8 +: 8];
        end
    endgenerate

    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic               granted_q, granted_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [127:0]       vra_q, vra_d;
    logic [127:0]       vrb_q, vrb_d;
    logic [7:0]         ins_q, ins_d;
    logic               rc_q, rc_d;
    logic               issue_en_q, issue_en_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [127:0]       rsp_vrt_q, rsp_vrt_d;
    logic               err_orphan_q, err_orphan_d;

    logic [IDW-1:0]     tag_mem [OUT_DEPTH];

    logic [IDW-1:0]     winner;
    logic [IDW-1:0]     cand;
    logic               found;
    logic               grant;
    logic               fifo_empty;
    logic               pop;
    logic [IDW-1:0]     head_id;

    // Round-robin search starting at the pointer, wrapping NUM_REQ-1 -> 0.
    always_comb begin
        winner = rr_ptr_q;
        cand   = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        granted_d    = 1'b0;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        vra_d        = vra_q;
        vrb_d        = vrb_q;
        ins_d        = ins_q;
        rc_d         = rc_q;
        issue_en_d   = 1'b0;
        rsp_valid_d  = '0;
        rsp_vrt_d    = rsp_vrt_q;
        err_orphan_d = err_orphan_q;
        req_ready    = '0;

        // The forced bubble after each grant gives the unit a cycle to raise dut_busy.
        grant = found && !dut_busy && !granted_q && (count_q < CW'(OUT_DEPTH));

        fifo_empty = (count_q == '0);
        // A completion while empty is only legitimate if the same edge pushes a tag.
        pop        = vrt_en && (!fifo_empty || grant);
        head_id    = fifo_empty ? winner : tag_mem[rd_ptr_q];

        if (grant) begin
            req_ready  = (rst) ? (NUM_REQ'(1) << winner) : '0;
            granted_d  = 1'b1;
            rr_ptr_d   = (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + IDW'(1);
            vra_d      = vra_arr[winner];
            vrb_d      = vrb_arr[winner];
            ins_d      = ins_arr[winner];
            rc_d       = req_rc[winner];
            issue_en_d = 1'b1;
            wr_ptr_d   = wr_ptr_q + PW'(1);
        end

        if (pop) begin
            rd_ptr_d    = rd_ptr_q + PW'(1);
            rsp_valid_d = NUM_REQ'(1) << head_id;
            rsp_vrt_d   = vrt;
        end else if (vrt_en) begin
            err_orphan_d = 1'b1;
        end

        case ({grant, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (grant) begin
            tag_mem[wr_ptr_q] <= winner;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q     <= '0;
            granted_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            vra_q        <= '0;
            vrb_q        <= '0;
            ins_q        <= '0;
            rc_q         <= 1'b0;
            issue_en_q   <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_vrt_q    <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            granted_q    <= granted_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            vra_q        <= vra_d;
            vrb_q        <= vrb_d;
            ins_q        <= ins_d;
            rc_q         <= rc_d;
            issue_en_q   <= issue_en_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_vrt_q    <= rsp_vrt_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    assign vra         = vra_q;
    assign vrb         = vrb_q;
    assign ins         = ins_q;
    assign rc          = rc_q;
    assign vra_en      = issue_en_q;
    assign vrb_en      = issue_en_q;
    assign ins_en      = issue_en_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_vrt     = rsp_vrt_q;
    assign outstanding = count_q;
    assign err_orphan  = err_orphan_q;

endmodule
